// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - two-source writeback arbiter for a single register file write port
// One-entry buffers per source, round-robin drain into a registered write stage, pending mask.
module wb_port_arbiter #(
  parameter int ADDR_SIZE     = 5,
  parameter int XLEN          = 32,
  parameter int NUM_REGISTERS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_SIZE-1:0]     alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_SIZE-1:0]     lsu_rd,
  input  logic [XLEN-1:0]          lsu_data,
  input  logic                     wb_stall,
  output logic                     write_enable,
  output logic [ADDR_SIZE-1:0]     write_addr,
  output logic [XLEN-1:0]          write_data,
  output logic [NUM_REGISTERS-1:0] pending
);

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  logic                 alu_buf_valid;
  logic [ADDR_SIZE-1:0] alu_buf_rd;
  logic [XLEN-1:0]      alu_buf_data;
  logic                 lsu_buf_valid;
  logic [ADDR_SIZE-1:0] lsu_buf_rd;
  logic [XLEN-1:0]      lsu_buf_data;
  logic                 last_grant;
  logic                 grant_alu;
  logic                 grant_lsu;
  logic                 alu_xfer;
  logic                 lsu_xfer;

  // Contention goes to whichever source did not win last time.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (!wb_stall) begin
      if (alu_buf_valid && lsu_buf_valid) begin
        grant_alu = (last_grant == SRC_LSU);
        grant_lsu = (last_grant == SRC_ALU);
      end else begin
        grant_alu = alu_buf_valid;
        grant_lsu = lsu_buf_valid;
      end
    end
  end

  assign alu_ready = !alu_buf_valid || grant_alu;
  assign lsu_ready = !lsu_buf_valid || grant_lsu;
  assign alu_xfer  = alu_valid && alu_ready;
  assign lsu_xfer  = lsu_valid && lsu_ready;

  // Writes to x0 complete the handshake but are discarded here.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_buf_valid <= 1'b0;
      alu_buf_rd    <= '0;
      alu_buf_data  <= '0;
    end else if (alu_xfer && (alu_rd != '0)) begin
      alu_buf_valid <= 1'b1;
      alu_buf_rd    <= alu_rd;
      alu_buf_data  <= alu_data;
    end else if (grant_alu) begin
      alu_buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lsu_buf_valid <= 1'b0;
      lsu_buf_rd    <= '0;
      lsu_buf_data  <= '0;
    end else if (lsu_xfer && (lsu_rd != '0)) begin
      lsu_buf_valid <= 1'b1;
      lsu_buf_rd    <= lsu_rd;
      lsu_buf_data  <= lsu_data;
    end else if (grant_lsu) begin
      lsu_buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      last_grant   <= SRC_ALU;
    end else if (grant_alu) begin
      write_enable <= 1'b1;
      write_addr   <= alu_buf_rd;
      write_data   <= alu_buf_data;
      last_grant   <= SRC_ALU;
    end else if (grant_lsu) begin
      write_enable <= 1'b1;
      write_addr   <= lsu_buf_rd;
      write_data   <= lsu_buf_data;
      last_grant   <= SRC_LSU;
    end else begin
      write_enable <= 1'b0;
    end
  end

  always_comb begin
    pending = '0;
    if (alu_buf_valid) pending[alu_buf_rd] = 1'b1;
    if (lsu_buf_valid) pending[lsu_buf_rd] = 1'b1;
    if (write_enable)  pending[write_addr] = 1'b1;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        wb_stall;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wb_stall(wb_stall),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    wb_stall = 1'b0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic expect_write(input string tag, input logic [4:0] addr, input logic [31:0] data);
    check({tag, "_we"}, write_enable, 1'b1);
    check({tag, "_addr"}, write_addr, addr);
    check({tag, "_data"}, write_data, data);
  endtask

  logic [31:0] alu_q[$];
  logic [31:0] lsu_q[$];

  initial begin
    int alu_sent, lsu_sent, alu_wr, lsu_wr;
    logic alu_x, lsu_x, prev_src, have_prev, src;
    logic [31:0] exp_data;

    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    wb_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_we", write_enable, 1'b0);
    check("rst_addr", write_addr, 5'd0);
    check("rst_data", write_data, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_alu_ready", alu_ready, 1'b1);
    check("rst_lsu_ready", lsu_ready, 1'b1);

    // 1: single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    check("t1_ready", alu_ready, 1'b1);
    step();
    alu_valid = 1'b0;
    #1;
    check("t1_e0_we", write_enable, 1'b0);
    check("t1_e0_pend", pending, 32'h20);
    step();
    expect_write("t1_e1", 5'd5, 32'hDEADBEEF);
    check("t1_e1_pend", pending, 32'h20);
    step();
    check("t1_e2_we", write_enable, 1'b0);
    check("t1_e2_pend", pending, 32'd0);

    // 2: simultaneous after reset, LSU wins first
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #1;
    check("t2_alu_ready_lo", alu_ready, 1'b0);
    check("t2_lsu_ready_hi", lsu_ready, 1'b1);
    check("t2_pend", pending, 32'h18);
    step();
    expect_write("t2_w0", 5'd4, 32'h22);
    check("t2_alu_ready_back", alu_ready, 1'b1);
    step();
    expect_write("t2_w1", 5'd3, 32'h11);
    step();
    check("t2_idle_we", write_enable, 1'b0);

    // 3: both sources streaming, scoreboard with alternation check
    alu_sent = 0; lsu_sent = 0; alu_wr = 0; lsu_wr = 0;
    have_prev = 1'b0; prev_src = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      alu_valid = (alu_sent < 8);
      alu_rd    = 5'd8 + 5'(alu_sent % 8);
      alu_data  = 32'hA000 + 32'(alu_sent);
      lsu_valid = (lsu_sent < 8);
      lsu_rd    = 5'd16 + 5'(lsu_sent % 8);
      lsu_data  = 32'hB000 + 32'(lsu_sent);
      #1;
      alu_x = alu_valid && alu_ready;
      lsu_x = lsu_valid && lsu_ready;
      step();
      if (alu_x) begin alu_q.push_back(alu_data); alu_sent++; end
      if (lsu_x) begin lsu_q.push_back(lsu_data); lsu_sent++; end
      if (write_enable) begin
        src = (write_addr >= 5'd16);
        if (have_prev) check("t3_alternate", src, !prev_src);
        have_prev = 1'b1;
        prev_src = src;
        if (!src) begin
          if (alu_q.size() == 0) check("t3_alu_extra", 1'b1, 1'b0);
          else begin exp_data = alu_q.pop_front(); check("t3_alu_data", write_data, exp_data); end
          alu_wr++;
        end else begin
          if (lsu_q.size() == 0) check("t3_lsu_extra", 1'b1, 1'b0);
          else begin exp_data = lsu_q.pop_front(); check("t3_lsu_data", write_data, exp_data); end
          lsu_wr++;
        end
      end
      if (alu_wr == 8 && lsu_wr == 8) break;
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    check("t3_alu_count", alu_wr, 8);
    check("t3_lsu_count", lsu_wr, 8);
    step();
    check("t3_drained_we", write_enable, 1'b0);
    check("t3_drained_pend", pending, 32'd0);

    // 4: writes to x0 are swallowed
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_ready", alu_ready, 1'b1);
      step();
      check("t4_we", write_enable, 1'b0);
      check("t4_pend", pending, 32'd0);
    end
    alu_valid = 1'b0;
    step();
    check("t4_after_we", write_enable, 1'b0);

    // 5: same destination, LSU then ALU
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hAAAA;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hBBBB;
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    step();
    expect_write("t5_w0", 5'd7, 32'hBBBB);
    step();
    expect_write("t5_w1", 5'd7, 32'hAAAA);
    step();
    check("t5_idle_we", write_enable, 1'b0);

    // 6a: stall with both buffers full
    do_reset();
    wb_stall = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h100;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'h200;
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #1;
    check("t6_alu_ready", alu_ready, 1'b0);
    check("t6_lsu_ready", lsu_ready, 1'b0);
    check("t6_pend", pending, 32'hC00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_stall_we", write_enable, 1'b0);
      check("t6_stall_pend", pending, 32'hC00);
    end
    wb_stall = 1'b0;
    step();
    expect_write("t6_w0", 5'd11, 32'h200);
    step();
    expect_write("t6_w1", 5'd10, 32'h100);
    step();
    check("t6_idle_we", write_enable, 1'b0);

    // 6b: reset with writes in flight
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h300;
    lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'h400;
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    step();
    check("t6b_inflight_we", write_enable, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t6b_we", write_enable, 1'b0);
    check("t6b_pend", pending, 32'd0);
    check("t6b_alu_ready", alu_ready, 1'b1);
    check("t6b_lsu_ready", lsu_ready, 1'b1);
    step();
    check("t6b_no_late_write", write_enable, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
